// File: rtl/match_ctrl.sv
// Scoreboard match clock: debounced start/pause and clear buttons, 1 Hz prescaler, MATCH_MIN:00 countdown.
// Optional expiry blink is built only when MATCH_CTRL_BLINK_EN is defined; otherwise blink is tied low.
module match_ctrl #(
   parameter int TICK_DIV   = 25000000,
   parameter int DEB_CYCLES = 250000,
   parameter int MATCH_MIN  = 5,
   parameter int BLINK_DIV  = 6250000
) (
   input  logic       clk_ctl,
   input  logic       rst_ctl,
   input  logic       btn_start_ctl,
   input  logic       btn_clear_ctl,
   output logic [3:0] sec_digit,
   output logic [2:0] dec_digit,
   output logic [3:0] min_digit,
   output logic       running,
   output logic       expired,
   output logic       blink
);

   localparam int NBTN      = 2;
   localparam int PW        = $clog2(TICK_DIV);
   localparam int DW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam bit START_EXP = (MATCH_MIN == 32'sd0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   state_t          state_r;
   logic [PW-1:0]   presc_r;
   logic [1:0]      raw_s;
   logic [1:0]      sync1_r;
   logic [1:0]      sync2_r;
   logic [1:0]      deb_r;
   logic [1:0]      deb_d_r;
   logic [1:0]      pulse_r;
   logic [DW-1:0]   deb_cnt_r [NBTN];
   logic            start_p_s;
   logic            clear_p_s;
   logic            tick_s;
   logic            zero_s;
   logic            enter_exp_s;
   logic [3:0]      sec_dn_s;
   logic [2:0]      dec_dn_s;
   logic [3:0]      min_dn_s;

   // bit 0 is start/pause, bit 1 is clear
   assign raw_s     = {btn_clear_ctl, btn_start_ctl};
   assign start_p_s = pulse_r[0];
   assign clear_p_s = pulse_r[1];

   // Synchronise, debounce and edge-detect both buttons
   always_ff @(posedge clk_ctl or posedge rst_ctl) begin
      if (rst_ctl) begin
         sync1_r <= 2'b00;
         sync2_r <= 2'b00;
         deb_r   <= 2'b00;
         deb_d_r <= 2'b00;
         pulse_r <= 2'b00;
         for (int b = 0; b < NBTN; b++) begin
            deb_cnt_r[b] <= {DW{1'b0}};
         end
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
         deb_d_r <= deb_r;
         pulse_r <= deb_r & ~deb_d_r;
         // the count only runs while the synchronised level disagrees with the accepted one
         for (int b = 0; b < NBTN; b++) begin
            if (sync2_r[b] == deb_r[b]) begin
               deb_cnt_r[b] <= {DW{1'b0}};
            end else if (deb_cnt_r[b] == DW'(DEB_CYCLES - 1)) begin
               deb_r[b]     <= sync2_r[b];
               deb_cnt_r[b] <= {DW{1'b0}};
            end else begin
               deb_cnt_r[b] <= deb_cnt_r[b] + DW'(1);
            end
         end
      end
   end

   // Tick detect, one-second decrement and expiry entry
   always_comb begin
      tick_s      = (state_r == ST_RUN) && (presc_r == PW'(TICK_DIV - 1));
      sec_dn_s    = 4'd0;
      dec_dn_s    = 3'd0;
      min_dn_s    = 4'd0;
      if (sec_digit != 4'd0) begin
         sec_dn_s = sec_digit - 4'd1;
         dec_dn_s = dec_digit;
         min_dn_s = min_digit;
      end else if (dec_digit != 3'd0) begin
         sec_dn_s = 4'd9;
         dec_dn_s = dec_digit - 3'd1;
         min_dn_s = min_digit;
      end else if (min_digit != 4'd0) begin
         sec_dn_s = 4'd9;
         dec_dn_s = 3'd5;
         min_dn_s = min_digit - 4'd1;
      end else begin
         sec_dn_s = 4'd0;
         dec_dn_s = 3'd0;
         min_dn_s = 4'd0;
      end
      zero_s      = (sec_dn_s == 4'd0) && (dec_dn_s == 3'd0) && (min_dn_s == 4'd0);
      enter_exp_s = !clear_p_s &&
                    (((state_r == ST_IDLE) && start_p_s && START_EXP) || (tick_s && zero_s));
   end

   // Match state machine with prescaler, digits and status outputs
   always_ff @(posedge clk_ctl or posedge rst_ctl) begin
      if (rst_ctl) begin
         state_r   <= ST_IDLE;
         presc_r   <= {PW{1'b0}};
         min_digit <= 4'(MATCH_MIN);
         dec_digit <= 3'd0;
         sec_digit <= 4'd0;
         running   <= 1'b0;
         expired   <= 1'b0;
      end else if (clear_p_s) begin
         state_r   <= ST_IDLE;
         presc_r   <= {PW{1'b0}};
         min_digit <= 4'(MATCH_MIN);
         dec_digit <= 3'd0;
         sec_digit <= 4'd0;
         running   <= 1'b0;
         expired   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_p_s) begin
                  if (enter_exp_s) begin
                     state_r <= ST_EXPIRED;
                     expired <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                     running <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               presc_r <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
               // a tick reaching 0:00 overrides a coincident pause request
               if (tick_s) begin
                  sec_digit <= sec_dn_s;
                  dec_digit <= dec_dn_s;
                  min_digit <= min_dn_s;
                  if (zero_s) begin
                     state_r <= ST_EXPIRED;
                     running <= 1'b0;
                     expired <= 1'b1;
                  end else if (start_p_s) begin
                     state_r <= ST_PAUSE;
                     running <= 1'b0;
                  end
               end else if (start_p_s) begin
                  state_r <= ST_PAUSE;
                  running <= 1'b0;
               end
            end
            ST_PAUSE: begin
               if (start_p_s) begin
                  state_r <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_EXPIRED: begin
               running <= 1'b0;
               expired <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
               running <= 1'b0;
               expired <= 1'b0;
            end
         endcase
      end
   end

`ifdef MATCH_CTRL_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   logic [BW-1:0] blink_cnt_r;

   // Expiry blink: starts lit on entry, toggles on every counter wrap
   always_ff @(posedge clk_ctl or posedge rst_ctl) begin
      if (rst_ctl) begin
         blink       <= 1'b0;
         blink_cnt_r <= {BW{1'b0}};
      end else if (clear_p_s) begin
         blink       <= 1'b0;
         blink_cnt_r <= {BW{1'b0}};
      end else if (enter_exp_s) begin
         blink       <= 1'b1;
         blink_cnt_r <= {BW{1'b0}};
      end else if (state_r == ST_EXPIRED) begin
         if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
            blink       <= ~blink;
            blink_cnt_r <= {BW{1'b0}};
         end else begin
            blink_cnt_r <= blink_cnt_r + BW'(1);
         end
      end else begin
         blink       <= 1'b0;
         blink_cnt_r <= {BW{1'b0}};
      end
   end
`else
   assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl: a seconds-based reference model checked every cycle,
// plus hand-computed pins at the scenario boundaries (reset, start, pause, expiry, priority, glitch).
module tb_match_ctrl;

   localparam int TICK = 4;
   localparam int DEB  = 2;
   localparam int MMIN = 1;
   localparam int BLK  = 3;
`ifdef MATCH_CTRL_BLINK_EN
   localparam int BLINK_ON = 1;
`else
   localparam int BLINK_ON = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       bs;
   logic       bc;
   logic [3:0] sec_digit;
   logic [2:0] dec_digit;
   logic [3:0] min_digit;
   logic       running;
   logic       expired;
   logic       blink;

   int checks = 0;
   int errors = 0;

   match_ctrl #(.TICK_DIV(TICK), .DEB_CYCLES(DEB), .MATCH_MIN(MMIN), .BLINK_DIV(BLK)) dut (
      .clk_ctl(clk), .rst_ctl(rst), .btn_start_ctl(bs), .btn_clear_ctl(bc),
      .sec_digit(sec_digit), .dec_digit(dec_digit), .min_digit(min_digit),
      .running(running), .expired(expired), .blink(blink)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic int dut_time();
      return int'(min_digit) * 100 + int'(dec_digit) * 10 + int'(sec_digit);
   endfunction

   // Reference model: remaining time in seconds, state 0 idle / 1 run / 2 pause / 3 expired
   logic [15:0] rh [2];
   bit          dn [2];
   bit          dp [2];
   bit          pc [2];
   int          ms, mst, mpre, mblink, mbcnt;

   always @(posedge clk or posedge rst) begin
      bit st_p, cl_p, np;
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            rh[b] = 16'h0000; dn[b] = 1'b0; dp[b] = 1'b0; pc[b] = 1'b0;
         end
         ms = MMIN * 60; mst = 0; mpre = 0; mblink = 0; mbcnt = 0;
      end else begin
         st_p = pc[0];
         cl_p = pc[1];
         // raw level seen two edges late, accepted once DEB successive samples agree
         for (int b = 0; b < 2; b++) begin
            rh[b] = {rh[b][14:0], (b == 0) ? bs : bc};
            np    = dn[b] & ~dp[b];
            dp[b] = dn[b];
            if (rh[b][DEB+1:2] == {DEB{1'b1}}) dn[b] = 1'b1;
            else if (rh[b][DEB+1:2] == {DEB{1'b0}}) dn[b] = 1'b0;
            pc[b] = np;
         end
         if (cl_p) begin
            mst = 0; ms = MMIN * 60; mpre = 0; mblink = 0; mbcnt = 0;
         end else begin
            case (mst)
               0: if (st_p) begin
                     if (MMIN == 0) begin mst = 3; mblink = 1; mbcnt = 0; end
                     else mst = 1;
                  end
               1: begin
                     if (mpre == TICK - 1) begin
                        mpre = 0;
                        ms   = ms - 1;
                        if (ms == 0) begin mst = 3; mblink = 1; mbcnt = 0; end
                        else if (st_p) mst = 2;
                     end else begin
                        mpre++;
                        if (st_p) mst = 2;
                     end
                  end
               2: if (st_p) mst = 1;
               default: begin
                     if (mbcnt == BLK - 1) begin mbcnt = 0; mblink = 1 - mblink; end
                     else mbcnt++;
                  end
            endcase
         end
      end
   end

   // Per-cycle comparison of all outputs against the model
   always @(posedge clk) begin
      int exp_v, got_v;
      #1;
      exp_v = ((ms / 60) * 100 + ((ms % 60) / 10) * 10 + (ms % 10)) * 1000
              + ((mst == 1) ? 100 : 0) + ((mst == 3) ? 10 : 0) + (BLINK_ON ? mblink : 0);
      got_v = dut_time() * 1000 + int'(running) * 100 + int'(expired) * 10 + int'(blink);
      check("cycle", got_v, exp_v);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int n);
      bs = 1'b1;
      cyc(n);
      bs = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bs = 1'b0; bc = 1'b0;
      #2;
      check("reset_time", dut_time(), 100);
      check("reset_flags", int'(running) * 100 + int'(expired) * 10 + int'(blink), 0);
      cyc(2); rst = 1'b0; cyc(2);

      // start: one pulse, first decrement on the 4th RUN cycle
      press(5); cyc(1);
      check("start_run", int'(running), 1);
      check("start_time", dut_time(), 100);
      cyc(3); check("pre_tick", dut_time(), 100);
      cyc(1); check("tick1", dut_time(), 59);
      cyc(4); check("tick2", dut_time(), 58);

      // pause mid-second, frozen, resume finishes the partial second
      press(5); cyc(1);
      check("pause_run", int'(running), 0);
      check("pause_time", dut_time(), 57);
      cyc(20); check("pause_frozen", dut_time(), 57);
      press(5); cyc(1);
      check("resume_run", int'(running), 1);
      cyc(1); check("resume_hold", dut_time(), 57);
      cyc(1); check("resume_tick", dut_time(), 56);

      // start coincident with tick: decrement applied and paused
      cyc(2); press(5); cyc(1);
      check("coinc_time", dut_time(), 54);
      check("coinc_flags", int'(running) * 100 + int'(expired) * 10, 0);

      // clear and start together mid-RUN: clear wins
      cyc(3); press(5); cyc(1);
      check("rerun", int'(running), 1);
      cyc(3);
      bs = 1'b1; bc = 1'b1; cyc(5); bs = 1'b0; bc = 1'b0; cyc(1);
      check("clr_time", dut_time(), 100);
      check("clr_run", int'(running), 0);

      // full run to expiry
      cyc(3); press(5); cyc(1);
      check("exp_start", int'(running), 1);
      cyc(239);
      check("exp_last_sec", dut_time(), 1);
      check("exp_not_yet", int'(expired), 0);
      cyc(1);
      check("exp_time", dut_time(), 0);
      check("exp_flags", int'(running) * 100 + int'(expired) * 10, 10);
      check("blink_entry", int'(blink), BLINK_ON);
      cyc(2); check("blink_hold", int'(blink), BLINK_ON);
      cyc(1); check("blink_toggle", int'(blink), 0);
      press(5); cyc(3);
      check("exp_ignore_start", int'(expired), 1);
      check("exp_ignore_time", dut_time(), 0);

      // clear out of EXPIRED, then glitch rejection
      cyc(3); bc = 1'b1; cyc(5); bc = 1'b0; cyc(1);
      check("clr_exp_time", dut_time(), 100);
      check("clr_exp_flags", int'(running) * 100 + int'(expired) * 10 + int'(blink), 0);
      cyc(4);
      bs = 1'b1; cyc(1); bs = 1'b0; cyc(2);
      bs = 1'b1; cyc(1); bs = 1'b0; cyc(1);
      bs = 1'b1; cyc(1); bs = 1'b0; cyc(1);
      cyc(8);
      check("glitch_idle", int'(running), 0);
      press(4); cyc(1);
      check("steady_pending", int'(running), 0);
      cyc(1); check("steady_run", int'(running), 1);
      cyc(10); check("steady_single", int'(running), 1);

      // asynchronous reset between edges while running
      @(negedge clk); #2; rst = 1'b1; #1;
      check("async_rst_time", dut_time(), 100);
      check("async_rst_flags", int'(running) * 100 + int'(expired) * 10 + int'(blink), 0);
      cyc(2); rst = 1'b0; cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
Scoreboard match-clock controller. Debounces the operator start/pause and clear buttons and runs the IDLE/RUN/PAUSE/EXPIRED state machine. Generates the 1 Hz tick from the 25 MHz pixel clock and counts match time down from MATCH_MIN:00. Its digit outputs feed the digit mux in place of the free-running timing block, and it flags expiry for the display stage.

Parameters:
TICK_DIV, 25000000, clk_ctl cycles per 1 s tick (>=2)
DEB_CYCLES, 250000, cycles an input must be stable before it is accepted (10 ms at 25 MHz; >=1)
MATCH_MIN, 5, match length in minutes (0..9)
BLINK_DIV, 6250000, half-period of expiry blink in cycles (4 Hz toggle = 2 Hz blink; >=1)

Ports:
clk_ctl  in  1  25 MHz pixel clock, rising edge
rst_ctl  in  1  asynchronous, active-high reset
btn_start_ctl  in  1  raw start/pause button, asynchronous to clk_ctl, active-high
btn_clear_ctl  in  1  raw clear button, asynchronous, active-high
sec_digit  out  4  seconds units, 0..9
dec_digit  out  3  seconds tens, 0..5
min_digit  out  4  minutes, 0..9
running  out  1  high in RUN
expired  out  1  high in EXPIRED
blink  out  1  expiry blink (see Optional Feature)

Behaviour:
- Reset (async, active-high):
  - state=IDLE
  - min_digit=MATCH_MIN, dec_digit=0, sec_digit=0
  - running=0, expired=0, blink=0
  - prescaler, debounce counters and synchronisers cleared
  - Reset asserted mid-RUN takes effect immediately, without waiting for a clock edge.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce counter: restarts on any change of the synchronised value. After DEB_CYCLES stable cycles the debounced level updates.
  - Rising-edge detect on the debounced level gives a 1-cycle pulse (start_p / clear_p).
  - Latency from stable raw input to pulse: DEB_CYCLES+3 cycles.
  - Holding a button produces exactly one pulse.
- FSM, priority clear_p > tick > start_p:
  - clear_p in any state -> IDLE; digits reloaded to MATCH_MIN:00; prescaler=0; blink=0.
  - IDLE + start_p -> RUN. If MATCH_MIN=0, IDLE + start_p -> EXPIRED instead.
  - RUN + start_p -> PAUSE. PAUSE + start_p -> RUN.
  - EXPIRED ignores start_p; only clear_p or reset leaves it.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; holds its value in PAUSE, so a resumed second is not restarted.
  - tick is asserted in the cycle where prescaler==TICK_DIV-1 and state==RUN; the prescaler wraps to 0 on that cycle.
  - Width is $clog2(TICK_DIV).
- Countdown, on tick, registered (digits change on the same edge the prescaler wraps):
  - sec>0: sec-1.
  - sec==0, dec>0: sec=9, dec-1.
  - sec==0, dec==0, min>0: sec=9, dec=5, min-1.
  - If the value after decrement is 0:00: state -> EXPIRED on that same edge, running=0, expired=1.
  - Digits never underflow. In EXPIRED they hold 0:00.
- Simultaneous events:
  - start_p and tick in the same cycle in RUN: the tick decrement is applied and state -> PAUSE, unless the decrement reaches 0:00, in which case state -> EXPIRED.
  - clear_p wins over both.
- running and expired are registered decodes of the state; they are never both high.

Optional Feature:
Macro: MATCH_CTRL_BLINK_EN
- Defined: a blink counter (0..BLINK_DIV-1) runs only in EXPIRED, and blink toggles at each wrap.
  - On entering EXPIRED, blink=1 and the counter=0.
  - Leaving EXPIRED forces blink=0.
- Not defined: the blink counter is not built and blink is tied to 0.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, DEB_CYCLES=2, MATCH_MIN=1, BLINK_DIV=3.
1. Reset: assert rst_ctl asynchronously between edges -> outputs immediately 1:0:0, running=0, expired=0, blink=0.
2. Start: 5-cycle start press -> one start_p, running=1. Digits go 0:5:9 on the 4th RUN cycle, then decrement every 4 cycles.
3. Pause: press start after 2 prescaler counts, hold PAUSE for 20 cycles, resume -> next decrement comes exactly 2 RUN cycles after resume. Digits are frozen during PAUSE.
4. Expiry: run 60 ticks -> 0:0:0 and expired=1 on the 60th tick edge. Further start presses are ignored. With MATCH_CTRL_BLINK_EN defined, blink toggles every 3 cycles.
5. Priority: clear and start pressed together mid-RUN -> IDLE, digits 1:0:0, running=0. Start+tick coincident -> digit decremented and state PAUSE.
6. Glitch: 1-cycle start pulse, then bouncing 1,0,1,0 at 1-cycle spacing -> no start_p. A 4-cycle steady press afterwards gives exactly one start_p.
